// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler
//   Merges two writeback streams (A: ALU, B: load) into a single register-file
//   write port. Each requester has its own QD-deep FIFO; one head entry is
//   popped per cycle using round-robin arbitration when both heads are valid.
//   Popped entries drive a registered write port; writes to x0 are dropped.
//   A combinational hazard query reports any queued or in-flight write.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   a_valid/a_ready/a_addr/a_data requester A push handshake and payload
//   b_valid/b_ready/b_addr/b_data requester B push handshake and payload
//   q_addr1/q_addr2, q_hit1/q_hit2 hazard query addresses and results
//   rf_we/rf_waddr/rf_wdata       registered register-file write port
//   idle                          both FIFOs empty and no write in flight
//
// Configuration
//   RF_SCHED_STATS_EN: adds grant_cnt_a / grant_cnt_b saturating 16-bit
//   per-port grant counters (x0 discards included).
module rf_write_scheduler #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 5,
  parameter int unsigned QD = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_hit1,
  output logic          q_hit2,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          idle
`ifdef RF_SCHED_STATS_EN
  ,
  output logic [15:0]   grant_cnt_a,
  output logic [15:0]   grant_cnt_b
`endif
);

  localparam int unsigned PW = (QD > 1) ? $clog2(QD) : 1;
  localparam int unsigned CW = $clog2(QD + 1);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Index 0 = requester A, index 1 = requester B.
  logic [1:0]    in_valid;
  logic [AW-1:0] in_addr [2];
  logic [DW-1:0] in_data [2];

  logic [CW-1:0] cnt    [2];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic [AW-1:0] mem_addr [2][QD];
  logic [DW-1:0] mem_data [2][QD];

  logic [1:0]    ready;
  logic [1:0]    nonempty;
  logic [1:0]    push;
  logic [1:0]    grant;
  logic          pop_any;
  logic          pop_sel;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  port_e         last_q;

  logic [PW-1:0] slot_off   [2][QD];
  logic          slot_valid [2][QD];

  always_comb begin
    in_valid   = {b_valid, a_valid};
    in_addr[0] = a_addr;
    in_addr[1] = b_addr;
    in_data[0] = a_data;
    in_data[1] = b_data;
  end

  // Handshake and round-robin arbitration. A full FIFO stays not-ready even
  // when it is popped this cycle.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      ready[p]    = (cnt[p] != CW'(QD));
      nonempty[p] = (cnt[p] != '0);
      push[p]     = in_valid[p] && ready[p];
    end
    grant[0]  = nonempty[0] && (!nonempty[1] || (last_q == PORT_B));
    grant[1]  = nonempty[1] && (!nonempty[0] || (last_q == PORT_A));
    pop_any   = |grant;
    pop_sel   = grant[1];
    head_addr = mem_addr[pop_sel][rd_ptr[pop_sel]];
    head_data = mem_data[pop_sel][rd_ptr[pop_sel]];
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];

  // State, pointers and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < 2; p++) begin
        cnt[p]    <= '0;
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
      last_q   <= PORT_B;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (push[p])  wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (grant[p]) rd_ptr[p] <= rd_ptr[p] + 1'b1;
        cnt[p] <= cnt[p] + CW'(push[p]) - CW'(grant[p]);
      end
      if (pop_any) last_q <= grant[0] ? PORT_A : PORT_B;
      rf_we <= pop_any && (head_addr != '0);
      if (pop_any && (head_addr != '0)) begin
        rf_waddr <= head_addr;
        rf_wdata <= head_data;
      end
    end
  end

  // FIFO storage needs no reset; occupancy counts define validity.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (push[p]) begin
        mem_addr[p][wr_ptr[p]] <= in_addr[p];
        mem_data[p][wr_ptr[p]] <= in_data[p];
      end
    end
  end

  // A slot is live when its distance from the read pointer (mod QD) is
  // below the occupancy count.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned j = 0; j < QD; j++) begin
        slot_off[p][j]   = PW'(j) - rd_ptr[p];
        slot_valid[p][j] = (CW'(slot_off[p][j]) < cnt[p]);
      end
    end
  end

  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned j = 0; j < QD; j++) begin
        if (slot_valid[p][j] && (mem_addr[p][j] == q_addr1)) q_hit1 = 1'b1;
        if (slot_valid[p][j] && (mem_addr[p][j] == q_addr2)) q_hit2 = 1'b1;
      end
    end
    if (rf_we && (rf_waddr == q_addr1)) q_hit1 = 1'b1;
    if (rf_we && (rf_waddr == q_addr2)) q_hit2 = 1'b1;
    if (q_addr1 == '0) q_hit1 = 1'b0;
    if (q_addr2 == '0) q_hit2 = 1'b0;
  end

  assign idle = (cnt[0] == '0) && (cnt[1] == '0) && !rf_we;

`ifdef RF_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else begin
      if (grant[0] && (grant_cnt_a != '1)) grant_cnt_a <= grant_cnt_a + 16'd1;
      if (grant[1] && (grant_cnt_b != '1)) grant_cnt_b <= grant_cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Testbench for rf_write_scheduler: randomized and directed pushes on both
// requesters, a queue-based reference model updated on each rising edge, and
// a monitor on the falling edge that pops expected writes from a scoreboard.
module tb_rf_write_scheduler;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned QD = 2;

  logic          clk;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic [AW-1:0] q_addr1, q_addr2;
  logic          q_hit1, q_hit2;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          idle;
`ifdef RF_SCHED_STATS_EN
  logic [15:0]   grant_cnt_a, grant_cnt_b;
`endif

  rf_write_scheduler #(.DW(DW), .AW(AW), .QD(QD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .q_addr1  (q_addr1),
    .q_addr2  (q_addr2),
    .q_hit1   (q_hit1),
    .q_hit2   (q_hit2),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .idle     (idle)
`ifdef RF_SCHED_STATS_EN
    ,
    .grant_cnt_a (grant_cnt_a),
    .grant_cnt_b (grant_cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  // Reference model: per-port queues, last-granted port, expected writes.
  ent_t qa[$];
  ent_t qb[$];
  ent_t exp_q[$];
  bit   last_b;
  int   sa, sb;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit_m(input logic [AW-1:0] q, input bit we, input logic [AW-1:0] wa);
    if (q == '0) return 1'b0;
    foreach (qa[i]) if (qa[i].addr == q) return 1'b1;
    foreach (qb[i]) if (qb[i].addr == q) return 1'b1;
    return we && (wa == q);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit   ra, rb;
    int   g;
    ent_t e;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      exp_q.delete();
      last_b = 1'b1;
      sa = 0;
      sb = 0;
    end else begin
      ra = (qa.size() < QD);
      rb = (qb.size() < QD);
      g  = -1;
      if (qa.size() > 0 && qb.size() > 0) g = last_b ? 0 : 1;
      else if (qa.size() > 0)             g = 0;
      else if (qb.size() > 0)             g = 1;
      if (g == 0) begin
        e = qa.pop_front(); last_b = 1'b0; sa++;
      end else if (g == 1) begin
        e = qb.pop_front(); last_b = 1'b1; sb++;
      end
      if (g >= 0 && e.addr != '0) exp_q.push_back(e);
      if (a_valid && ra) qa.push_back('{a_addr, a_data});
      if (b_valid && rb) qb.push_back('{b_addr, b_data});
    end
  end

  // Monitor: compares every falling edge, pops the scoreboard on rf_we.
  initial begin
    bit            exp_we;
    logic [AW-1:0] exp_wa;
    ent_t          e;
    m_waddr = '0;
    m_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        m_waddr = '0;
        m_wdata = '0;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_idle", idle, 1);
`ifdef RF_SCHED_STATS_EN
        chk("rst_cnt_a", grant_cnt_a, 0);
        chk("rst_cnt_b", grant_cnt_b, 0);
`endif
      end else begin
        exp_we = (exp_q.size() != 0);
        exp_wa = exp_we ? exp_q[0].addr : '0;
        chk("a_ready", a_ready, qa.size() < QD);
        chk("b_ready", b_ready, qb.size() < QD);
        chk("idle", idle, (qa.size() == 0) && (qb.size() == 0) && !exp_we);
        chk("q_hit1", q_hit1, hit_m(q_addr1, exp_we, exp_wa));
        chk("q_hit2", q_hit2, hit_m(q_addr2, exp_we, exp_wa));
        chk("rf_we", rf_we, exp_we);
        if (exp_we) begin
          e = exp_q.pop_front();
          m_waddr = e.addr;
          m_wdata = e.data;
        end
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
`ifdef RF_SCHED_STATS_EN
        chk("grant_cnt_a", grant_cnt_a, (sa > 65535) ? 65535 : sa);
        chk("grant_cnt_b", grant_cnt_b, (sb > 65535) ? 65535 : sb);
`endif
      end
    end
  end

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    q_addr1 = '0;   q_addr2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet(2);

    // Single A write to x5.
    q_addr1 = 5'd5; q_addr2 = 5'd0;
    drive(1'b1, 5'd5, 64'h11, 1'b0, '0, '0);
    quiet(5);

    // Two simultaneous pairs: alternation A, B, A, B.
    drive(1'b1, 5'd1, 64'hA1, 1'b1, 5'd2, 64'hB1);
    drive(1'b1, 5'd3, 64'hA2, 1'b1, 5'd4, 64'hB2);
    quiet(6);

    // B kept non-empty while A pushes three times back to back.
    drive(1'b0, '0, '0, 1'b1, 5'd10, 64'hB10);
    drive(1'b1, 5'd11, 64'hA11, 1'b1, 5'd12, 64'hB12);
    drive(1'b1, 5'd13, 64'hA13, 1'b1, 5'd14, 64'hB14);
    drive(1'b1, 5'd15, 64'hA15, 1'b1, 5'd16, 64'hB16);
    quiet(10);

    // Write to x0 from B is discarded.
    drive(1'b0, '0, '0, 1'b1, 5'd0, 64'hFF);
    quiet(4);

    // Hazard query on x7.
    q_addr1 = 5'd7; q_addr2 = 5'd0;
    drive(1'b1, 5'd7, 64'h77, 1'b0, '0, '0);
    quiet(5);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      q_addr1 = AW'($urandom_range(0, 7));
      q_addr2 = AW'($urandom_range(0, 7));
      drive($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), {$urandom, $urandom});
    end
    quiet(6);

    // Reset while both queues hold entries.
    for (int i = 0; i < 4; i++)
      drive(1'b1, AW'(i + 1), {$urandom, $urandom}, 1'b1, AW'(i + 20), {$urandom, $urandom});
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet(10);

    @(negedge clk);
    #2;
    chk("final_idle", idle, 1);
    chk("drain", exp_q.size() + qa.size() + qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
